wb_arbiter2: RTL and testbench

- Two-master round-robin arbiter sharing one pipelined Wishbone slave (stb/stall/ack, no cyc). Typical slave: bootrom or RAM.
- Master 0 is the cpu core; master 1 is a second requester (VGA fetch / DMA).
- Sits between the masters and the slave in soc; owns the grant, the request/response muxing and the count of outstanding transactions.

---
 rtl/wb_arbiter2.sv | 193 +++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
//   Two-master round-robin arbiter in front of one pipelined Wishbone slave
//   (stb/stall/ack, no cyc). Master 0 is the cpu core, master 1 a secondary
//   requester (VGA fetch / DMA). The arbiter owns the grant, the request and
//   response muxing, and the count of accepted-but-unacked requests.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   i_m0_* / o_m0_*            master 0: stb, we, addr, wdata in;
//                              stall, ack, rdata out
//   i_m1_* / o_m1_*            master 1: same as master 0
//   o_s_*                      slave request: stb, we, addr, wdata
//   i_s_stall, i_s_ack,        slave response: stall, ack, rdata
//   i_s_data
//
// Parameters
//   AW       word address width
//   DW       data width
//   MAX_OUT  max accepted-but-unacked requests, 1..15 (4-bit count)
//
// State table
//   state | meaning
//   IDLE  | no owner; all masters stalled, slave acks dropped
//   OWN0  | master 0 owns the slave; its requests/acks are forwarded
//   OWN1  | master 1 owns the slave; its requests/acks are forwarded
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int AW      = 7,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_data,
  output logic          o_m0_stall,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m0_data,

  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_data,
  output logic          o_m1_stall,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m1_data,

  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  input  logic          i_s_stall,
  input  logic          i_s_ack,
  input  logic [DW-1:0] i_s_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       last_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic       cnt_full;
  logic       cnt_zero;
  logic       accept;
  logic       ack_in;

  assign cnt_full = (cnt == MAX_CNT);
  assign cnt_zero = (cnt == 4'd0);

  // Accept uses the muxed strobe so a full count or IDLE never counts.
  assign accept = o_s_stb && !i_s_stall;
  // Acks arriving with no owner (e.g. left over from before a reset) are
  // discarded and must not touch the count.
  assign ack_in = i_s_ack && (state != IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Only master strobes and the registered count feed the
  // grant decision, so slave stall/ack never reach the state register
  // combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (i_m0_stb && i_m1_stb) begin
          // tie goes to whichever master was not served last
          state_nxt = last ? OWN0 : OWN1;
        end else if (i_m0_stb) begin
          state_nxt = OWN0;
        end else if (i_m1_stb) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        // hold the grant while stb is up or responses are still in flight
        if (!i_m0_stb && cnt_zero) begin
          last_nxt  = 1'b0;
          state_nxt = i_m1_stb ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!i_m1_stb && cnt_zero) begin
          last_nxt  = 1'b1;
          state_nxt = i_m0_stb ? OWN0 : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outstanding-request counter. Simultaneous accept and ack cancel out; a
  // stray ack at zero saturates rather than wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_nxt = cnt;
    case ({accept, ack_in})
      2'b10:   cnt_nxt = cnt + 4'd1;
      2'b01:   cnt_nxt = cnt_zero ? 4'd0 : (cnt - 4'd1);
      default: cnt_nxt = cnt;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: request mux toward the slave, response demux toward the
  // owner. Everything not owned is held at its idle value.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_m0_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m0_data  = '0;
    o_m1_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_data  = '0;
    case (state)
      OWN0: begin
        o_s_stb    = i_m0_stb && !cnt_full;
        o_s_we     = i_m0_we;
        o_s_addr   = i_m0_addr;
        o_s_data   = i_m0_data;
        o_m0_stall = i_s_stall || cnt_full;
        o_m0_ack   = i_s_ack;
        o_m0_data  = i_s_data;
      end
      OWN1: begin
        o_s_stb    = i_m1_stb && !cnt_full;
        o_s_we     = i_m1_we;
        o_s_addr   = i_m1_addr;
        o_s_data   = i_m1_data;
        o_m1_stall = i_s_stall || cnt_full;
        o_m1_ack   = i_s_ack;
        o_m1_data  = i_s_data;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2
//   Directed, cycle-by-cycle bench for wb_arbiter2. Inputs change 1 ns after
//   the rising edge; outputs and internal state are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;
  localparam int AW      = 7;
  localparam int DW      = 32;
  localparam int MAX_OUT = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_m0_stb, i_m0_we;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_data;
  logic          o_m0_stall, o_m0_ack;
  logic [DW-1:0] o_m0_data;
  logic          i_m1_stb, i_m1_we;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_data;
  logic          o_m1_stall, o_m1_ack;
  logic [DW-1:0] o_m1_data;
  logic          o_s_stb, o_s_we;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_data;
  logic          i_s_stall, i_s_ack;
  logic [DW-1:0] i_s_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_m0_stb   (i_m0_stb),
    .i_m0_we    (i_m0_we),
    .i_m0_addr  (i_m0_addr),
    .i_m0_data  (i_m0_data),
    .o_m0_stall (o_m0_stall),
    .o_m0_ack   (o_m0_ack),
    .o_m0_data  (o_m0_data),
    .i_m1_stb   (i_m1_stb),
    .i_m1_we    (i_m1_we),
    .i_m1_addr  (i_m1_addr),
    .i_m1_data  (i_m1_data),
    .o_m1_stall (o_m1_stall),
    .o_m1_ack   (o_m1_ack),
    .o_m1_data  (o_m1_data),
    .o_s_stb    (o_s_stb),
    .o_s_we     (o_s_we),
    .o_s_addr   (o_s_addr),
    .o_s_data   (o_s_data),
    .i_s_stall  (i_s_stall),
    .i_s_ack    (i_s_ack),
    .i_s_data   (i_s_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    i_m0_stb  = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_data = '0;
    i_m1_stb  = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_data = '0;
    i_s_stall = 1'b0; i_s_ack = 1'b0; i_s_data  = '0;
  endtask

  task automatic do_reset;
    idle_inputs;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // One single-request tenure of master `own`, both masters strobing.
  // Entry: owner just granted. Exit: owner re-strobes, grant should have moved.
  task automatic burst1(input int own, input logic [31:0] rd);
    logic [1:0] st;
    st = (own == 0) ? S_OWN0 : S_OWN1;
    settle;
    chk("rr_owner", 32'(dut.state), 32'(st));
    chk("rr_s_stb", 32'(o_s_stb), 32'd1);
    chk("rr_addr", 32'(o_s_addr), (own == 0) ? 32'h10 : 32'h20);
    tick;
    if (own == 0) i_m0_stb = 1'b0; else i_m1_stb = 1'b0;
    i_s_ack  = 1'b1;
    i_s_data = rd;
    settle;
    chk("rr_ack_owner", 32'((own == 0) ? o_m0_ack : o_m1_ack), 32'd1);
    chk("rr_ack_other", 32'((own == 0) ? o_m1_ack : o_m0_ack), 32'd0);
    chk("rr_rdata", (own == 0) ? o_m0_data : o_m1_data, rd);
    tick;
    i_s_ack = 1'b0;
    settle;
    chk("rr_hold", 32'(dut.state), 32'(st));
    chk("rr_cnt0", 32'(dut.cnt), 32'd0);
    tick;
    if (own == 0) i_m0_stb = 1'b1; else i_m1_stb = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values (inputs busy to prove they are masked)
    idle_inputs;
    reset     = 1'b1;
    i_m0_stb  = 1'b1;
    i_m0_addr = 7'h55;
    i_m0_data = 32'hCAFE_F00D;
    i_s_ack   = 1'b1;
    i_s_data  = 32'h1234_5678;
    tick;
    tick;
    settle;
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));
    chk("rst_cnt", 32'(dut.cnt), 32'd0);
    chk("rst_last", 32'(dut.last), 32'd1);
    chk("rst_s_stb", 32'(o_s_stb), 32'd0);
    chk("rst_s_addr", 32'(o_s_addr), 32'd0);
    chk("rst_s_data", o_s_data, 32'd0);
    chk("rst_m0_stall", 32'(o_m0_stall), 32'd1);
    chk("rst_m1_stall", 32'(o_m1_stall), 32'd1);
    chk("rst_m0_ack", 32'(o_m0_ack), 32'd0);
    chk("rst_m0_data", o_m0_data, 32'd0);
    chk("rst_m1_data", o_m1_data, 32'd0);

    // ---------------- single read from m0
    do_reset;
    i_m0_stb  = 1'b1;
    i_m0_addr = 7'h05;
    settle;
    chk("rd_c0_state", 32'(dut.state), 32'(S_IDLE));
    chk("rd_c0_stall", 32'(o_m0_stall), 32'd1);
    tick;
    settle;
    chk("rd_c1_state", 32'(dut.state), 32'(S_OWN0));
    chk("rd_c1_s_stb", 32'(o_s_stb), 32'd1);
    chk("rd_c1_addr", 32'(o_s_addr), 32'h05);
    chk("rd_c1_we", 32'(o_s_we), 32'd0);
    chk("rd_c1_stall", 32'(o_m0_stall), 32'd0);
    tick;
    i_m0_stb = 1'b0;
    i_s_ack  = 1'b1;
    i_s_data = 32'hDEAD_BEEF;
    settle;
    chk("rd_c2_ack", 32'(o_m0_ack), 32'd1);
    chk("rd_c2_data", o_m0_data, 32'hDEAD_BEEF);
    chk("rd_c2_m1_ack", 32'(o_m1_ack), 32'd0);
    chk("rd_c2_cnt", 32'(dut.cnt), 32'd1);
    tick;
    i_s_ack = 1'b0;
    settle;
    chk("rd_c3_cnt", 32'(dut.cnt), 32'd0);
    chk("rd_c3_state", 32'(dut.state), 32'(S_OWN0));
    tick;
    settle;
    chk("rd_c4_state", 32'(dut.state), 32'(S_IDLE));
    chk("rd_c4_last", 32'(dut.last), 32'd0);

    // ---------------- tie and round-robin
    do_reset;
    i_m0_stb  = 1'b1;
    i_m0_addr = 7'h10;
    i_m1_stb  = 1'b1;
    i_m1_addr = 7'h20;
    settle;
    chk("rr_start_idle", 32'(dut.state), 32'(S_IDLE));
    tick;
    burst1(0, 32'hA000_0001);
    burst1(1, 32'hB000_0002);
    burst1(0, 32'hA000_0003);
    burst1(1, 32'hB000_0004);
    settle;
    chk("rr_final_owner", 32'(dut.state), 32'(S_OWN0));
    idle_inputs;

    // ---------------- outstanding limit, accept+ack, stray ack
    do_reset;
    i_m0_stb  = 1'b1;
    i_m0_we   = 1'b1;
    i_m0_addr = 7'h33;
    i_m0_data = 32'hA5A5_0000;
    settle;
    chk("lim_c0_state", 32'(dut.state), 32'(S_IDLE));
    tick;
    for (int k = 0; k < 4; k++) begin
      settle;
      chk("lim_s_stb", 32'(o_s_stb), 32'd1);
      chk("lim_cnt", 32'(dut.cnt), 32'(k));
      tick;
    end
    i_s_ack = 1'b1;
    settle;
    chk("lim_full_cnt", 32'(dut.cnt), 32'd4);
    chk("lim_full_s_stb", 32'(o_s_stb), 32'd0);
    chk("lim_full_stall", 32'(o_m0_stall), 32'd1);
    tick;
    i_s_ack = 1'b0;
    settle;
    chk("lim_ack_cnt", 32'(dut.cnt), 32'd3);
    chk("lim_ack_s_stb", 32'(o_s_stb), 32'd1);
    chk("lim_ack_stall", 32'(o_m0_stall), 32'd0);
    tick;
    i_s_ack = 1'b1;
    settle;
    chk("lim_refill_cnt", 32'(dut.cnt), 32'd4);
    chk("lim_refill_s_stb", 32'(o_s_stb), 32'd0);
    tick;
    settle;
    chk("both_pre_cnt", 32'(dut.cnt), 32'd3);
    chk("both_s_stb", 32'(o_s_stb), 32'd1);
    tick;
    i_m0_stb = 1'b0;
    settle;
    chk("both_post_cnt", 32'(dut.cnt), 32'd3);
    tick;
    tick;
    tick;
    settle;
    chk("drain_cnt", 32'(dut.cnt), 32'd0);
    chk("drain_state", 32'(dut.state), 32'(S_OWN0));
    chk("stray_ack_fwd", 32'(o_m0_ack), 32'd1);
    tick;
    settle;
    chk("stray_ack_sat", 32'(dut.cnt), 32'd0);
    chk("stray_release", 32'(dut.state), 32'(S_IDLE));
    chk("idle_ack_drop", 32'(o_m0_ack), 32'd0);
    idle_inputs;

    // ---------------- reset mid-burst in OWN1
    do_reset;
    i_m1_stb  = 1'b1;
    i_m1_addr = 7'h44;
    tick;
    settle;
    chk("mid_c1_state", 32'(dut.state), 32'(S_OWN1));
    tick;
    tick;
    i_m1_stb = 1'b0;
    reset    = 1'b1;
    settle;
    chk("mid_pre_cnt", 32'(dut.cnt), 32'd2);
    tick;
    reset    = 1'b0;
    i_s_ack  = 1'b1;
    i_s_data = 32'hBAD0_BAD0;
    settle;
    chk("mid_ack1_m1", 32'(o_m1_ack), 32'd0);
    chk("mid_ack1_data", o_m1_data, 32'd0);
    chk("mid_state", 32'(dut.state), 32'(S_IDLE));
    chk("mid_cnt", 32'(dut.cnt), 32'd0);
    tick;
    i_m0_stb  = 1'b1;
    i_m0_addr = 7'h0A;
    settle;
    chk("mid_ack2_m1", 32'(o_m1_ack), 32'd0);
    chk("mid_ack2_m0", 32'(o_m0_ack), 32'd0);
    tick;
    i_s_ack = 1'b0;
    settle;
    chk("post_cnt", 32'(dut.cnt), 32'd0);
    chk("post_state", 32'(dut.state), 32'(S_OWN0));
    chk("post_s_stb", 32'(o_s_stb), 32'd1);
    chk("post_addr", 32'(o_s_addr), 32'h0A);
    tick;
    i_m0_stb = 1'b0;
    i_s_ack  = 1'b1;
    i_s_data = 32'h0000_600D;
    settle;
    chk("post_ack", 32'(o_m0_ack), 32'd1);
    chk("post_data", o_m0_data, 32'h0000_600D);
    tick;
    i_s_ack = 1'b0;
    tick;
    settle;
    chk("post_idle", 32'(dut.state), 32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
